// File: rtl/pio_button_poll_master_pkg.sv
// Shared types and helpers for the PIO button poll master.
// Holds the poll FSM state encoding and the counter-width helper that every
// block uses to size its timers from its own parameters.
package pio_poll_pkg;

  // Poll sequencer states: wait out the poll interval, issue the read,
  // then count down the fixed slave read latency before capturing data.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } poll_state_t;

  // Legal parameter ceilings; sub-blocks size their counters from the
  // actual parameter values with cnt_width().
  localparam int MAX_WIDTH            = 32;
  localparam int MAX_READ_LATENCY     = 4;
  localparam int MAX_DEBOUNCE_SAMPLES = 15;

  // Bits needed to hold a down/up counter spanning 0..n-1 (at least 1 bit).
  function automatic int cnt_width(input int n);
    if (n <= 1) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/pio_button_poll_master_if.sv
// Bus bundle for the poll master: the Avalon-MM read side toward the PIO
// slave and the button event stream toward fabric logic.
//
// Event stream handshake: the producer raises event_valid with the
// event_press/event_release fields and keeps them unchanged until a cycle in
// which event_valid and event_ready are both 1; that cycle is the transfer.
// The consumer may drive event_ready at any time, independent of event_valid.
interface pio_button_poll_master_if #(
  parameter int WIDTH = 2
) ();

  logic [1:0]       avm_address;
  logic             avm_read;
  logic             avm_waitrequest;
  logic [31:0]      avm_readdata;

  logic             event_valid;
  logic             event_ready;
  logic [WIDTH-1:0] event_press;
  logic [WIDTH-1:0] event_release;

  // Poll master side: drives the read and produces events.
  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata,
    output event_valid,
    output event_press,
    output event_release,
    input  event_ready
  );

  // Peer side: the PIO slave answers reads and the consumer takes events.
  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata,
    input  event_valid,
    input  event_press,
    input  event_release,
    output event_ready
  );

endinterface

// File: rtl/pio_button_poll_master_debounce.sv
// Single-bit debouncer driven by poll captures.
// The stable state only follows the sample after DEBOUNCE_SAMPLES consecutive
// captures that disagree with it; any agreeing capture restarts the count.
// rise/fall are combinational pulses in the capture cycle so the parent can
// register them alongside the new stable value.
module pio_debounce_bit
  import pio_poll_pkg::*;
#(
  parameter int DEBOUNCE_SAMPLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic sample_en,
  input  logic sample,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int CW = cnt_width(DEBOUNCE_SAMPLES);
  localparam logic [CW:0] LAST_COUNT = (CW+1)'(DEBOUNCE_SAMPLES);

  logic [CW-1:0] r_cnt;
  logic          r_stable;
  logic [CW:0]   w_cnt_inc;
  logic          w_differ;
  logic          w_accept;

  // One extra bit keeps cnt+1 from wrapping before the compare.
  assign w_cnt_inc = {1'b0, r_cnt} + (CW+1)'(1);
  assign w_differ  = sample_en && (sample != r_stable);
  assign w_accept  = w_differ && (w_cnt_inc == LAST_COUNT);

  // Disagreement counter and stable state, advanced only on captures
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else if (sample_en) begin
      if (!w_differ) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_stable <= sample;
        r_cnt    <= '0;
      end else begin
        r_cnt <= w_cnt_inc[CW-1:0];
      end
    end
  end

  assign stable = r_stable;
  assign rise   = w_accept && sample;
  assign fall   = w_accept && !sample;

endmodule

// File: rtl/pio_button_poll_master.sv
// Avalon-MM read master that polls a PIO input slave at a fixed interval,
// debounces every polled bit and reports press/release events on a
// valid/ready stream, so fabric logic sees buttons without a CPU.
// Legal ranges: WIDTH 1..32, POLL_CYCLES >= 1, READ_LATENCY 1..4,
// DEBOUNCE_SAMPLES 1..15.
module pio_button_poll_master
  import pio_poll_pkg::*;
#(
  parameter int WIDTH            = 2,
  parameter int POLL_CYCLES      = 50000,
  parameter int READ_LATENCY     = 1,
  parameter int DEBOUNCE_SAMPLES = 4,
  parameter int ACTIVE_LOW       = 1,
  parameter int POLL_ADDR        = 0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  pio_button_poll_master_if.master        bus,
  output logic [WIDTH-1:0]                button_state,
  output logic                            overflow,
  input  logic                            clear_overflow,
  output poll_state_t                     o_dbg_state
);

  localparam int TW = cnt_width(POLL_CYCLES);
  localparam int LW = cnt_width(READ_LATENCY);
  localparam logic [TW-1:0] TMR_RELOAD = TW'(POLL_CYCLES - 1);
  localparam logic [LW-1:0] LAT_RELOAD = LW'(READ_LATENCY - 1);
  localparam logic [1:0]    ADDR       = 2'(POLL_ADDR);

  // ---------------------------------------------------------------------
  // Poll sequencer
  // ---------------------------------------------------------------------
  poll_state_t   r_state;
  poll_state_t   w_state_nxt;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_timer_nxt;
  logic [LW-1:0] r_lat;
  logic [LW-1:0] w_lat_nxt;
  logic          w_capture;

  // FSM state, poll interval timer and read-latency counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_timer <= TMR_RELOAD;
      r_lat   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_lat   <= w_lat_nxt;
    end
  end

  // Next state: count down the interval, hold the read through wait states,
  // then wait out the slave latency and flag the capture cycle.
  // Dropping enable mid-read lets the read finish; IDLE then parks the timer.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_lat_nxt   = r_lat;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!enable) begin
          w_timer_nxt = TMR_RELOAD;
        end else if (r_timer == '0) begin
          w_state_nxt = REQ;
          w_timer_nxt = TMR_RELOAD;
        end else begin
          w_timer_nxt = r_timer - TW'(1);
        end
      end
      REQ: begin
        if (!bus.avm_waitrequest) begin
          w_state_nxt = WAIT;
          w_lat_nxt   = LAT_RELOAD;
        end
      end
      WAIT: begin
        if (r_lat == '0) begin
          w_capture   = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_lat_nxt = r_lat - LW'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_timer_nxt = TMR_RELOAD;
      end
    endcase
  end

  // Read strobe decodes straight from the state register so an async reset
  // drops it immediately and abandons any read in flight.
  assign bus.avm_read    = (r_state == REQ);
  assign bus.avm_address = ADDR;
  assign o_dbg_state     = r_state;

  // ---------------------------------------------------------------------
  // Sample conditioning and per-bit debounce
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] w_raw;
  logic [WIDTH-1:0] w_sample;
  logic [WIDTH-1:0] w_stable;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic             w_unused_rdata;

  assign w_raw          = bus.avm_readdata[WIDTH-1:0];
  assign w_sample       = (ACTIVE_LOW != 0) ? ~w_raw : w_raw;
  // Bits above WIDTH are read but carry nothing of interest.
  assign w_unused_rdata = ^bus.avm_readdata;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    pio_debounce_bit #(
      .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)
    ) u_debounce (
      .clk      (clk),
      .reset    (reset),
      .sample_en(w_capture),
      .sample   (w_sample[gi]),
      .stable   (w_stable[gi]),
      .rise     (w_rise[gi]),
      .fall     (w_fall[gi])
    );
  end

  assign button_state = w_stable;

  // ---------------------------------------------------------------------
  // Event register
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] r_press;
  logic [WIDTH-1:0] r_release;
  logic             r_valid;
  logic             r_overflow;
  logic             w_new;
  logic             w_accept;
  logic             w_merge;

  assign w_new    = |{w_rise, w_fall};
  assign w_accept = r_valid && bus.event_ready;
  // A new event that cannot be handed over this cycle folds into the pending
  // one; the consumer then sees the union and the overflow flag.
  assign w_merge  = w_new && r_valid && !bus.event_ready;

  // Pending event fields: load fresh, merge while stalled, clear on transfer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_press   <= '0;
      r_release <= '0;
      r_valid   <= 1'b0;
    end else if (w_merge) begin
      r_press   <= r_press | w_rise;
      r_release <= r_release | w_fall;
    end else if (w_new) begin
      r_press   <= w_rise;
      r_release <= w_fall;
      r_valid   <= 1'b1;
    end else if (w_accept) begin
      r_press   <= '0;
      r_release <= '0;
      r_valid   <= 1'b0;
    end
  end

  // Sticky overflow; a merge in the same cycle beats clear_overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_merge) begin
      r_overflow <= 1'b1;
    end else if (clear_overflow) begin
      r_overflow <= 1'b0;
    end
  end

  assign bus.event_valid   = r_valid;
  assign bus.event_press   = r_press;
  assign bus.event_release = r_release;
  assign overflow          = r_overflow;

endmodule
